// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite channel bundle between the load/store unit and data memory.
// The master side drives address/data/valids; the slave drives readies and responses.
interface axi_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;
    logic [1:0]              rresp;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rdata, rvalid, rresp
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bvalid, bresp,
        output arready, rdata, rvalid, rresp
    );
endinterface

// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: one request at a time onto AXI4-Lite,
// with byte-lane placement for stores and aligned, extended load data.
module lsu_axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_misaligned,
    axi_intf.master               axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic                  aw_done;
    logic                  w_done;

    logic                  bad_req;
    logic [3:0]            strb_req;
    logic                  accept;
    logic                  awvalid_c;
    logic                  wvalid_c;
    logic                  arvalid_c;
    logic                  rready_c;
    logic [31:0]           rd_shift;
    logic [31:0]           rd_ext;
    logic                  unused_ok;

    assign accept = (state == IDLE) && req_valid;

    // Unsigned sizes are only meaningful for loads; anything else is rejected.
    always_comb begin
        bad_req  = 1'b0;
        strb_req = 4'b0000;
        case (req_funct3)
            3'b000: strb_req = 4'b0001 << req_addr[1:0];
            3'b001: begin
                bad_req  = req_addr[0];
                strb_req = 4'b0011 << req_addr[1:0];
            end
            3'b010: begin
                bad_req  = |req_addr[1:0];
                strb_req = 4'b1111;
            end
            3'b100: bad_req = req_we;
            3'b101: bad_req = req_we | req_addr[0];
            default: bad_req = 1'b1;
        endcase
    end

    assign rd_shift = axi.rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        arvalid_c = 1'b0;
        rready_c  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_req)     state_nx = RESP;
                    else if (req_we) state_nx = WR;
                    else             state_nx = RD_ADDR;
                end
            end
            WR: begin
                awvalid_c = !aw_done;
                wvalid_c  = !w_done;
                if ((aw_done || axi.awready) && (w_done || axi.wready))
                    state_nx = RESP;
            end
            RD_ADDR: begin
                arvalid_c = 1'b1;
                if (axi.arready) state_nx = RD_DATA;
            end
            RD_DATA: begin
                rready_c = 1'b1;
                if (axi.rvalid) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address/data/strobe stay put after completion: the slave commits late.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q         <= '0;
            funct3_q       <= 3'b000;
            wdata_q        <= '0;
            wstrb_q        <= 4'b0000;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_misaligned <= 1'b0;
        end else if (accept) begin
            addr_q         <= req_addr;
            funct3_q       <= req_funct3;
            wdata_q        <= req_wdata << {req_addr[1:0], 3'b000};
            wstrb_q        <= (req_we && !bad_req) ? strb_req : 4'b0000;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_misaligned <= bad_req;
        end else begin
            if (awvalid_c && axi.awready) aw_done <= 1'b1;
            if (wvalid_c && axi.wready)   w_done  <= 1'b1;
            if (rready_c && axi.rvalid)   rsp_rdata <= rd_ext;
        end
    end

    assign req_ready   = aresetn && (state == IDLE);
    assign axi.awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign axi.araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign axi.awvalid = awvalid_c;
    assign axi.wvalid  = wvalid_c;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = 1'b1;
    assign axi.arvalid = arvalid_c;
    assign axi.rready  = rready_c;

    // Writes are posted and read errors are not reported to the core.
    assign unused_ok = ^{axi.bvalid, axi.bresp, axi.rresp};

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: directed vector table plus hand sequences
// for a stalled write address channel and reset during a read.
module tb_lsu_axi_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;

    int total = 0;
    int bad = 0;

    axi_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    lsu_axi_master dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .axi            (axi)
    );

    always #5 aclk = ~aclk;

    // BRAM-style slave: one-cycle read latency, awaddr is the only address.
    logic [31:0] mem [256];
    logic        aw_seen;
    logic        w_seen;

    assign axi.bvalid = 1'b0;
    assign axi.bresp  = 2'b00;
    assign axi.rresp  = 2'b00;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_seen   <= 1'b0;
            w_seen    <= 1'b0;
            axi.rvalid <= 1'b0;
            axi.rdata  <= 32'd0;
        end else begin
            if (aw_seen && w_seen) begin
                for (int i = 0; i < 4; i++)
                    if (axi.wstrb[i])
                        mem[axi.awaddr[9:2]][8*i +: 8] <= axi.wdata[8*i +: 8];
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
            end else begin
                if (axi.awvalid && axi.awready) aw_seen <= 1'b1;
                if (axi.wvalid && axi.wready)   w_seen  <= 1'b1;
            end
            axi.rvalid <= axi.arvalid && axi.arready;
            if (axi.arvalid && axi.arready)
                axi.rdata <= mem[axi.awaddr[9:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wd;
        int          exp_lat;
    } vec_t;

    // Per-request observations collected by do_req.
    int          o_lat;
    logic [31:0] o_rd;
    logic        o_mis;
    logic        o_saw;
    logic [3:0]  o_strb;
    logic [31:0] o_wd;
    logic [31:0] o_aa;

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge aclk);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge aclk);
        #1 req_valid = 1'b0;
        o_lat  = -1;
        o_saw  = 1'b0;
        o_strb = 4'h0;
        o_wd   = 32'd0;
        o_aa   = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge aclk);
            if (axi.awvalid || axi.wvalid) begin
                o_strb = axi.wstrb;
                o_wd   = axi.wdata;
                o_aa   = axi.awaddr;
            end
            if (axi.awvalid || axi.wvalid || axi.arvalid) o_saw = 1'b1;
            if (rsp_valid) begin
                o_lat = c;
                o_rd  = rsp_rdata;
                o_mis = rsp_misaligned;
                chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
                break;
            end
        end
        if (o_lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    vec_t tbl [14];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.arready = 1'b1;

        tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 2};
        tbl[1]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0,        3};
        tbl[2]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'hA5000000, 2};
        tbl[3]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFA5, 1'b0, 4'b0000, 32'h0,        3};
        tbl[4]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h000000A5, 1'b0, 4'b0000, 32'h0,        3};
        tbl[5]  = '{1'b1, 3'b001, 32'h102, 32'h00008001, 32'h0,        1'b0, 4'b1100, 32'h80010000, 2};
        tbl[6]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF8001, 1'b0, 4'b0000, 32'h0,        3};
        tbl[7]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h00008001, 1'b0, 4'b0000, 32'h0,        3};
        tbl[8]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        1};
        tbl[9]  = '{1'b1, 3'b001, 32'h103, 32'h0000FFFF, 32'h0,        1'b1, 4'b0000, 32'h0,        1};
        tbl[10] = '{1'b1, 3'b100, 32'h100, 32'h00000011, 32'h0,        1'b1, 4'b0000, 32'h0,        1};
        tbl[11] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        1};
        tbl[12] = '{1'b0, 3'b000, 32'h100, 32'h0,        32'hFFFFFFEF, 1'b0, 4'b0000, 32'h0,        3};
        tbl[13] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h8001BEEF, 1'b0, 4'b0000, 32'h0,        3};

        repeat (2) @(negedge aclk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid,
                           axi.rready, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mis", {31'd0, rsp_misaligned}, 32'd0);
        chk("rst_wstrb", {28'd0, axi.wstrb}, 32'd0);
        chk("rst_addr", axi.awaddr, 32'd0);
        chk("rst_wdata", axi.wdata, 32'd0);
        aresetn = 1'b1;
        #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd);
            chk($sformatf("v%0d_lat", i), o_lat, tbl[i].exp_lat);
            chk($sformatf("v%0d_rdata", i), o_rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_mis", i), {31'd0, o_mis}, {31'd0, tbl[i].exp_mis});
            if (tbl[i].exp_mis)
                chk($sformatf("v%0d_no_bus", i), {31'd0, o_saw}, 32'd0);
            else if (tbl[i].we) begin
                chk($sformatf("v%0d_wstrb", i), {28'd0, o_strb}, {28'd0, tbl[i].exp_strb});
                chk($sformatf("v%0d_wdata", i), o_wd, tbl[i].exp_wd);
                chk($sformatf("v%0d_awaddr", i), o_aa, {tbl[i].addr[31:2], 2'b00});
            end
        end

        // Write address channel stalled for three cycles, W goes first.
        axi.awready = 1'b0;
        @(negedge aclk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        req_wdata  = 32'h12345678;
        @(posedge aclk);
        #1 req_valid = 1'b0;
        o_lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge aclk);
            if (rsp_valid) begin
                o_lat = c;
                break;
            end
            if (c <= 4) begin
                chk($sformatf("stall_awvalid_c%0d", c), {31'd0, axi.awvalid}, 32'd1);
                chk($sformatf("stall_awaddr_c%0d", c), axi.awaddr, 32'h200);
                chk($sformatf("stall_wdata_c%0d", c), axi.wdata, 32'h12345678);
            end
            if (c == 1) chk("stall_wvalid_c1", {31'd0, axi.wvalid}, 32'd1);
            if (c == 2) chk("stall_wvalid_c2", {31'd0, axi.wvalid}, 32'd0);
            if (c == 4) axi.awready = 1'b1;
        end
        chk("stall_lat", o_lat, 5);

        // Reset lands while the load sits in RD_DATA.
        @(negedge aclk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        @(posedge aclk);
        #1 req_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk("rd_data_rready", {31'd0, axi.rready}, 32'd1);
        aresetn = 1'b0;
        #1;
        chk("abort_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid,
                             axi.rready, rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            chk($sformatf("abort_rsp_c%0d", c), {31'd0, rsp_valid}, 32'd0);
        end
        aresetn = 1'b1;
        #1 chk("abort_rdata", rsp_rdata, 32'd0);

        do_req(1'b0, 3'b010, 32'h200, 32'h0);
        chk("after_rst_lat", o_lat, 3);
        chk("after_rst_rdata", o_rd, 32'h12345678);
        chk("after_rst_mis", {31'd0, o_mis}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
